// File: rtl/perm_unit.sv
// perm_unit: execution unit for the MOVPERMUTE custom-instruction family.
//
// Holds NUM_SLOTS shuffle registers together with a write pointer and a read
// pointer. Single-cycle ops load slots, read slots and move the pointers.
// PERMUTE runs an in-place Fisher-Yates shuffle over all slots, one swap per
// cycle, with swap indices taken from an internal Galois LFSR. While a shuffle
// runs the unit drops ready_o and raises hold_o to stall the pipeline.
//
// Ports:
//   clk         clock
//   rst         asynchronous reset, active high
//   req_i       op request, taken only while ready_o is high
//   op_i        funct3 op code (0 MOVTOSH .. 6 MOVTORDIND, 7 illegal)
//   rs1_data_i  rs1 operand
//   imm_i       12-bit I-type immediate, sign-extended for IMMTOSH
//   ready_o     high only while idle
//   hold_o      inverse of ready_o, pipeline stall request
//   rd_data_o   read result, held between reads
//   rd_valid_o  one-cycle pulse when rd_data_o carries a fresh read
//   done_o      one-cycle pulse at the end of PERMUTE
//   illegal_o   one-cycle pulse for op 7
//   rd_idx_o    current read pointer
module perm_unit #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLOTS = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    localparam int               IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [11:0]       imm_i,
    output logic              ready_o,
    output logic              hold_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              done_o,
    output logic              illegal_o,
    output logic [IDX_W-1:0]  rd_idx_o
);

    localparam logic [2:0] OP_MOVTOSH    = 3'd0;
    localparam logic [2:0] OP_IMMTOSH    = 3'd1;
    localparam logic [2:0] OP_PERMUTE    = 3'd2;
    localparam logic [2:0] OP_MOVTORD    = 3'd3;
    localparam logic [2:0] OP_INITIND    = 3'd4;
    localparam logic [2:0] OP_INCIND     = 3'd5;
    localparam logic [2:0] OP_MOVTORDIND = 3'd6;

    // Galois feedback masks for right-shifting LFSRs; 8 and 16 are maximal length.
    function automatic logic [LFSR_W-1:0] lfsr_taps();
        case (LFSR_W)
            8:       lfsr_taps = LFSR_W'(8'hB8);
            16:      lfsr_taps = LFSR_W'(16'hB400);
            default: lfsr_taps = {1'b1, {(LFSR_W-1){1'b0}}} | LFSR_W'(16'hB400);
        endcase
    endfunction

    localparam logic [LFSR_W-1:0] TAPS = lfsr_taps();

    // One Galois step: shift right, fold the feedback mask in when bit 0 was set.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        if (v[0]) begin
            lfsr_step = (v >> 1) ^ TAPS;
        end else begin
            lfsr_step = v >> 1;
        end
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PERM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   slots [NUM_SLOTS];
    logic [IDX_W-1:0]    wr_ptr;
    logic [IDX_W-1:0]    rd_ptr;
    logic [IDX_W-1:0]    idx;
    logic [LFSR_W-1:0]   lfsr;
    logic [2*IDX_W-1:0]  prod;
    logic [IDX_W-1:0]    j_sel;
    logic                accept;
    logic [DATA_W-1:0]   imm_sext;

    assign accept   = req_i & ready_o;
    assign imm_sext = {{(DATA_W-12){imm_i[11]}}, imm_i};
    assign rd_idx_o = rd_ptr;

    // Swap partner j = (r * (i+1)) >> IDX_W with r = low LFSR bits, so 0 <= j <= i.
    always_comb begin
        prod  = (2*IDX_W)'(lfsr[IDX_W-1:0]) * ((2*IDX_W)'(idx) + (2*IDX_W)'(1));
        j_sel = IDX_W'(prod >> IDX_W);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; the last swap is the one with idx == 1.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && (op_i == OP_PERMUTE)) begin
                    state_next = S_PERM;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_PERM: begin
                if (idx == IDX_W'(1)) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_PERM;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        ready_o = 1'b0;
        done_o  = 1'b0;
        case (state)
            S_IDLE:  ready_o = 1'b1;
            S_PERM:  ready_o = 1'b0;
            S_DONE:  done_o  = 1'b1;
            default: ready_o = 1'b0;
        endcase
        hold_o = ~ready_o;
    end

    // Datapath: slot file, pointers, LFSR and registered result/pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slots[k] <= {DATA_W{1'b0}};
            end
            wr_ptr     <= {IDX_W{1'b0}};
            rd_ptr     <= {IDX_W{1'b0}};
            idx        <= {IDX_W{1'b0}};
            lfsr       <= SEED;
            rd_data_o  <= {DATA_W{1'b0}};
            rd_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
            if (accept) begin
                case (op_i)
                    OP_MOVTOSH: begin
                        slots[wr_ptr] <= rs1_data_i;
                        wr_ptr        <= wr_ptr + IDX_W'(1);
                    end
                    OP_IMMTOSH: begin
                        slots[wr_ptr] <= rs1_data_i + imm_sext;
                        wr_ptr        <= wr_ptr + IDX_W'(1);
                    end
                    OP_PERMUTE: begin
                        idx <= IDX_W'(NUM_SLOTS - 1);
                        // A zero seed would lock the LFSR, so it keeps its value instead.
                        if (rs1_data_i[LFSR_W-1:0] != {LFSR_W{1'b0}}) begin
                            lfsr <= rs1_data_i[LFSR_W-1:0];
                        end else begin
                            lfsr <= lfsr;
                        end
                    end
                    OP_MOVTORD: begin
                        rd_data_o  <= slots[rs1_data_i[IDX_W-1:0]];
                        rd_valid_o <= 1'b1;
                    end
                    OP_INITIND: begin
                        rd_ptr <= {IDX_W{1'b0}};
                        wr_ptr <= {IDX_W{1'b0}};
                    end
                    OP_INCIND: begin
                        rd_ptr <= rd_ptr + IDX_W'(1);
                    end
                    OP_MOVTORDIND: begin
                        rd_data_o  <= slots[rd_ptr];
                        rd_valid_o <= 1'b1;
                    end
                    default: begin
                        illegal_o <= 1'b1;
                    end
                endcase
            end else if (state == S_PERM) begin
                // When j == idx both writes carry the same value, leaving the slot intact.
                slots[idx]   <= slots[j_sel];
                slots[j_sel] <= slots[idx];
                lfsr         <= lfsr_step(lfsr);
                idx          <= idx - IDX_W'(1);
            end else begin
                lfsr <= lfsr;
            end
        end
    end

endmodule

// File: tb/tb_perm_unit.sv
module tb_perm_unit;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_data_i;
    logic [11:0] imm_i;
    logic        ready_o;
    logic        hold_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        done_o;
    logic        illegal_o;
    logic [2:0]  rd_idx_o;

    int checks;
    int errors;

    logic [31:0] exp_slots [8];
    // Shuffle of 0x10..0x17 with seed 0xACE1, worked out by hand step by step.
    logic [31:0] perm_ace1 [8];

    perm_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .imm_i      (imm_i),
        .ready_o    (ready_o),
        .hold_o     (hold_o),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .done_o     (done_o),
        .illegal_o  (illegal_o),
        .rd_idx_o   (rd_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op at the negedge; returns 1 time unit after the accepting posedge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] rs1, input logic [11:0] imm);
        @(negedge clk);
        req_i      = 1'b1;
        op_i       = op;
        rs1_data_i = rs1;
        imm_i      = imm;
        @(posedge clk);
        #1;
        req_i = 1'b0;
    endtask

    task automatic load_slots(input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            do_op(3'd0, base + 32'(k), 12'h000);
        end
    endtask

    // Reference shuffle written straight from the algorithm description.
    task automatic model_shuffle(input logic [15:0] seed);
        int          l;
        int          j;
        logic [31:0] t;
        l = int'(seed);
        for (int i = 7; i >= 1; i--) begin
            j = ((l % 8) * (i + 1)) / 8;
            t = exp_slots[i];
            exp_slots[i] = exp_slots[j];
            exp_slots[j] = t;
            if ((l % 2) == 1) begin
                l = (l / 2) ^ 32'h0000B400;
            end else begin
                l = l / 2;
            end
        end
    endtask

    // Runs from just after the accept edge until ready returns; counts busy cycles and done pulses.
    task automatic wait_perm(input string name, input bit poke_busy);
        int busy;
        int dones;
        int hold_bad;
        busy = 0; dones = 0; hold_bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (hold_o !== ~ready_o) hold_bad++;
            if (ready_o === 1'b1) break;
            busy++;
            if (done_o === 1'b1) dones++;
            if (poke_busy && busy == 3) begin
                req_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'hDEAD; imm_i = 12'h000;
            end
            if (poke_busy && busy == 5) req_i = 1'b0;
            @(posedge clk);
            #1;
        end
        req_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: ready=%b after 40 cycles, required 1", name, ready_o);
        end
        checks++;
        if (busy != 8) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d, required 8", name, busy);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d, required 1", name, dones);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL %s_hold: hold!=~ready in %0d cycles, required 0", name, hold_bad);
        end
    endtask

    task automatic check_slots(input string name);
        for (int k = 0; k < 8; k++) begin
            do_op(3'd3, 32'(k), 12'h000);
            checks++;
            if (rd_data_o !== exp_slots[k]) begin
                errors++;
                $display("FAIL %s_slot%0d: got %h, required %h", name, k, rd_data_o, exp_slots[k]);
            end
        end
    endtask

    task automatic test_reset();
        do_op(3'd0, 32'h55, 12'h000);
        do_op(3'd5, 32'h0, 12'h000);
        do_op(3'd3, 32'h0, 12'h000);
        checks++;
        if (rd_data_o !== 32'h55 || rd_valid_o !== 1'b1 || rd_idx_o !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset: data=%h valid=%b idx=%0d, required 55/1/1", rd_data_o, rd_valid_o, rd_idx_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || hold_o !== 1'b0 || rd_data_o !== 32'h0 || rd_valid_o !== 1'b0 ||
            done_o !== 1'b0 || illegal_o !== 1'b0 || rd_idx_o !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b hold=%b data=%h v=%b done=%b ill=%b idx=%0d, required 1 0 0 0 0 0 0",
                     ready_o, hold_o, rd_data_o, rd_valid_o, done_o, illegal_o, rd_idx_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_movtosh();
        load_slots(32'h10);
        do_op(3'd0, 32'hAA, 12'h000);
        do_op(3'd3, 32'd0, 12'h000);
        checks++;
        if (rd_data_o !== 32'hAA || rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL movtord_wrap: data=%h valid=%b, required 000000aa/1", rd_data_o, rd_valid_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid_o !== 1'b0 || rd_data_o !== 32'hAA) begin
            errors++;
            $display("FAIL rd_valid_pulse: valid=%b data=%h, required 0/000000aa", rd_valid_o, rd_data_o);
        end
        do_op(3'd3, 32'd3, 12'h000);
        checks++;
        if (rd_data_o !== 32'h13 || rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL movtord_3: data=%h valid=%b, required 00000013/1", rd_data_o, rd_valid_o);
        end
    endtask

    task automatic test_immtosh();
        do_op(3'd1, 32'h100, 12'hFFF);
        do_op(3'd1, 32'hFFFF_FFFF, 12'h001);
        do_op(3'd3, 32'd1, 12'h000);
        checks++;
        if (rd_data_o !== 32'hFF) begin
            errors++;
            $display("FAIL immtosh_neg: got %h, required 000000ff", rd_data_o);
        end
        do_op(3'd3, 32'd2, 12'h000);
        checks++;
        if (rd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL immtosh_wrap: got %h, required 00000000", rd_data_o);
        end
    endtask

    task automatic test_permute();
        do_op(3'd4, 32'h0, 12'h000);
        load_slots(32'h10);
        do_op(3'd2, 32'h0, 12'h000);
        wait_perm("perm_seed", 1'b1);
        for (int k = 0; k < 8; k++) exp_slots[k] = perm_ace1[k];
        check_slots("perm_seed");
    endtask

    task automatic test_indirect();
        do_op(3'd4, 32'h0, 12'h000);
        for (int k = 0; k < 9; k++) do_op(3'd5, 32'h0, 12'h000);
        checks++;
        if (rd_idx_o !== 3'd1) begin
            errors++;
            $display("FAIL incind_wrap: idx=%0d, required 1", rd_idx_o);
        end
        do_op(3'd6, 32'h0, 12'h000);
        checks++;
        if (rd_data_o !== perm_ace1[1] || rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL movtordind: data=%h valid=%b, required %h/1", rd_data_o, rd_valid_o, perm_ace1[1]);
        end
        do_op(3'd7, 32'h3, 12'h000);
        checks++;
        if (illegal_o !== 1'b1 || rd_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL illegal_pulse: ill=%b valid=%b rdy=%b, required 1/0/1", illegal_o, rd_valid_o, ready_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (illegal_o !== 1'b0 || rd_idx_o !== 3'd1 || rd_data_o !== perm_ace1[1]) begin
            errors++;
            $display("FAIL illegal_nochange: ill=%b idx=%0d data=%h, required 0/1/%h",
                     illegal_o, rd_idx_o, rd_data_o, perm_ace1[1]);
        end
        do_op(3'd3, 32'd0, 12'h000);
        checks++;
        if (rd_data_o !== perm_ace1[0]) begin
            errors++;
            $display("FAIL illegal_slots: slot0=%h, required %h", rd_data_o, perm_ace1[0]);
        end
    endtask

    task automatic test_reset_in_perm();
        load_slots(32'h10);
        do_op(3'd2, 32'h1234, 12'h000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL perm_busy: ready=%b in PERM cycle 3, required 0", ready_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || hold_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_perm: rdy=%b hold=%b done=%b, required 1/0/0", ready_o, hold_o, done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) exp_slots[k] = 32'h0;
        check_slots("after_rst");
        // LFSR back at SEED: a zero-seed PERMUTE repeats the first shuffle.
        load_slots(32'h10);
        do_op(3'd2, 32'h0, 12'h000);
        wait_perm("perm_reseed", 1'b0);
        for (int k = 0; k < 8; k++) exp_slots[k] = perm_ace1[k];
        check_slots("perm_reseed");
        load_slots(32'h20);
        do_op(3'd2, 32'h1234, 12'h000);
        wait_perm("perm_1234", 1'b0);
        for (int k = 0; k < 8; k++) exp_slots[k] = 32'h20 + 32'(k);
        model_shuffle(16'h1234);
        check_slots("perm_1234");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        perm_ace1[0] = 32'h17; perm_ace1[1] = 32'h15; perm_ace1[2] = 32'h14; perm_ace1[3] = 32'h13;
        perm_ace1[4] = 32'h12; perm_ace1[5] = 32'h16; perm_ace1[6] = 32'h10; perm_ace1[7] = 32'h11;
        rst        = 1'b1;
        req_i      = 1'b0;
        op_i       = 3'd0;
        rs1_data_i = 32'h0;
        imm_i      = 12'h000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_movtosh();
        test_immtosh();
        test_permute();
        test_indirect();
        test_reset_in_perm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
